// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit arbiter: byte width,
//               arbiter state encoding and a round-robin wrap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_LAUNCH     = 2'd1,
    ARB_WAIT_START = 2'd2,
    ARB_WAIT_DONE  = 2'd3
  } arb_state_t;

  // Index following idx in a ring of n entries.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx,
                                              input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester byte streams plus the uart_tx handshake, bundled for
//               the arbiter.
//   req_valid  [NUM_REQ]      requester i has a byte pending
//   req_data   [8*NUM_REQ]    byte from requester i in bits [8i+7:8i]
//   req_last   [NUM_REQ]      byte closes its frame
//   req_ready  [NUM_REQ]      one-cycle accept (transfer on valid & ready)
//   tx_busy                   from uart_tx
//   tx_enable / tx_data       to uart_tx
//   grant_id   [ID_W]         current or most recent owner
//   locked                    frame in progress, grant held
//   err_timeout               pulse when tx_busy failed to rise
//   master : requester/uart side     slave : arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [UART_BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx_busy;
  logic                           tx_enable;
  logic [UART_BYTE_W-1:0]         tx_data;
  logic [ID_W-1:0]                grant_id;
  logic                           locked;
  logic                           err_timeout;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_enable, tx_data, grant_id, locked, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_enable, tx_data, grant_id, locked, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker. Returns the first eligible
//               index at or above rr_ptr, wrapping modulo NUM_REQ.
//   eligible   [NUM_REQ]  candidate mask
//   rr_ptr     [ID_W]     search start index (< NUM_REQ)
//   winner_oh  [NUM_REQ]  one-hot winner, all zero when nothing eligible
//   winner_idx [ID_W]     winner index, zero when nothing eligible
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [ID_W-1:0]    winner_idx
);

  int w_best_dist;
  int w_dist;

  // Each candidate's distance from rr_ptr going upward with wrap; the smallest
  // distance wins. This avoids a variable index into the mask.
  always_comb begin
    winner_oh   = '0;
    winner_idx  = '0;
    w_best_dist = NUM_REQ;
    w_dist      = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (j >= int'(rr_ptr)) begin
        w_dist = j - int'(rr_ptr);
      end else begin
        w_dist = j + NUM_REQ - int'(rr_ptr);
      end
      if (eligible[j] && (w_dist < w_best_dist)) begin
        w_best_dist  = w_dist;
        winner_oh    = '0;
        winner_oh[j] = 1'b1;
        winner_idx   = ID_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one uart_tx between NUM_REQ byte-stream requesters.
//               Round-robin per frame, with the grant held from the first
//               byte of a frame until its last byte (or a start timeout).
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    uart_tx_arbiter_if.slave (requester streams + uart_tx handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 8,
  parameter int ID_W          = 2
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.slave    bus
);

  localparam int c_cnt_w = $clog2(START_TIMEOUT + 1);

  arb_state_t             r_state;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [c_cnt_w-1:0]     r_start_cnt;
  logic                   r_tx_enable;
  logic [UART_BYTE_W-1:0] r_tx_data;
  logic                   r_last;
  logic [ID_W-1:0]        r_grant_id;
  logic                   r_locked;
  logic                   r_err_timeout;

  logic [NUM_REQ-1:0]     w_owner_mask;
  logic [NUM_REQ-1:0]     w_eligible;
  logic [NUM_REQ-1:0]     w_win_oh;
  logic [ID_W-1:0]        w_win_idx;
  logic                   w_grant;
  logic [UART_BYTE_W-1:0] w_sel_data;
  logic                   w_sel_last;
  logic [ID_W-1:0]        w_rr_next;
  logic [c_cnt_w-1:0]     w_cnt_next;

  // While a frame is locked only its owner may be granted.
  always_comb begin
    w_owner_mask = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_owner_mask[j] = (r_grant_id == ID_W'(j));
    end
    w_eligible = r_locked ? (bus.req_valid & w_owner_mask) : bus.req_valid;
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .eligible   (w_eligible),
    .rr_ptr     (r_rr_ptr),
    .winner_oh  (w_win_oh),
    .winner_idx (w_win_idx)
  );

  assign w_grant = (r_state == ARB_IDLE) && !bus.tx_busy && (|w_eligible);

  // Byte and last flag of the winner, selected by the one-hot vector.
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win_oh[j]) begin
        w_sel_data = bus.req_data[j*UART_BYTE_W +: UART_BYTE_W];
        w_sel_last = bus.req_last[j];
      end
    end
  end

  assign w_rr_next  = ID_W'(rr_wrap_inc(int'(r_grant_id), NUM_REQ));
  assign w_cnt_next = r_start_cnt + c_cnt_w'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ARB_IDLE;
      r_rr_ptr      <= '0;
      r_start_cnt   <= '0;
      r_tx_enable   <= 1'b0;
      r_tx_data     <= '0;
      r_last        <= 1'b0;
      r_grant_id    <= '0;
      r_locked      <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_tx_enable   <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant) begin
            r_tx_data   <= w_sel_data;
            r_last      <= w_sel_last;
            r_grant_id  <= w_win_idx;
            r_tx_enable <= 1'b1;
            r_state     <= ARB_LAUNCH;
          end
        end
        ARB_LAUNCH: begin
          r_start_cnt <= '0;
          r_state     <= ARB_WAIT_START;
        end
        ARB_WAIT_START: begin
          if (bus.tx_busy) begin
            r_state <= ARB_WAIT_DONE;
          end else begin
            r_start_cnt <= w_cnt_next;
            // uart_tx never acknowledged: drop the byte and release the lock.
            if (w_cnt_next == c_cnt_w'(START_TIMEOUT)) begin
              r_err_timeout <= 1'b1;
              r_locked      <= 1'b0;
              r_rr_ptr      <= w_rr_next;
              r_state       <= ARB_IDLE;
            end
          end
        end
        ARB_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_state <= ARB_IDLE;
            if (r_last) begin
              r_locked <= 1'b0;
              r_rr_ptr <= w_rr_next;
            end else begin
              r_locked <= 1'b1;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = w_grant ? w_win_oh : '0;
  assign bus.tx_enable   = r_tx_enable;
  assign bus.tx_data     = r_tx_data;
  assign bus.grant_id    = r_grant_id;
  assign bus.locked      = r_locked;
  assign bus.err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. Requesters are byte
//               queues, uart_tx is a small busy-timer model, and a frame-level
//               reference model predicts every grant, lock and line byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ       = 4;
  localparam int START_TIMEOUT = 8;
  localparam int ID_W          = 2;
  localparam int BUSY_LEN      = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .START_TIMEOUT (START_TIMEOUT),
    .ID_W          (ID_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;

  // Requester byte queues: {last, data}
  logic [8:0]         rq [NUM_REQ][$];
  logic [NUM_REQ-1:0] gate;
  bit                 quiet, rst_req, ext_busy_req, rand_gate;

  // uart_tx model
  logic ext_busy;
  logic uart_dead;
  int   uart_cnt;
  logic uart_busy;
  logic [7:0] line_act[$];

  assign uart_busy   = (uart_cnt != 0);
  assign bus.tx_busy = uart_busy | ext_busy;

  always @(posedge clk) begin
    if (reset) begin
      uart_cnt <= 0;
    end else if (uart_cnt != 0) begin
      uart_cnt <= uart_cnt - 1;
    end else if (bus.tx_enable && !uart_dead) begin
      uart_cnt <= BUSY_LEN;
      line_act.push_back(bus.tx_data);
    end
  end

  // Reference model state
  int         m_ptr, m_owner;
  bit         m_locked;
  bit         exp_en;
  logic [7:0] exp_data;
  int         exp_gid;
  int         en_age;
  bit         err_pending;
  int         err_seen;
  int         grant_log[$];
  logic [7:0] line_exp[$];
  int         exp_grants[$];
  logic [7:0] exp_line[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert (obs === expv) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Winner per the arbitration rules: owner only while locked, else the
  // first valid requester scanning upward from the pointer with wrap.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic cycle();
    logic [NUM_REQ-1:0] v;
    logic [8:0] front;
    int w, exp_w;
    bit exp_e;
    v = '0;
    @(negedge clk);
    reset    = rst_req;
    ext_busy = ext_busy_req;
    for (int i = 0; i < NUM_REQ; i++) begin
      gate[i] = rand_gate ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rq[i].size() > 0) begin
        bus.req_data[8*i +: 8] = rq[i][0][7:0];
        bus.req_last[i]        = rq[i][0][8];
        v[i] = gate[i] && !quiet;
      end
    end
    bus.req_valid = v;
    #1;
    chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
    if (bus.tx_busy) chk("ready_while_busy", 32'(bus.req_ready), 0);
    if (exp_en || bus.tx_enable) begin
      chk("tx_enable", 32'(bus.tx_enable), 32'(exp_en));
      if (exp_en) begin
        chk("tx_data", 32'(bus.tx_data), 32'(exp_data));
        chk("grant_id", 32'(bus.grant_id), exp_gid);
      end
    end
    if (bus.tx_enable) en_age = 0;
    else if (en_age < 1000) en_age++;
    exp_en = 0;
    exp_e = err_pending && (en_age == START_TIMEOUT + 1);
    if (bus.err_timeout) err_seen++;
    if (exp_e || bus.err_timeout) begin
      chk("err_timeout", 32'(bus.err_timeout), 32'(exp_e));
      if (exp_e) begin
        chk("err_locked", 32'(bus.locked), 0);
        err_pending = 0;
      end
    end
    if (bus.req_ready != '0) begin
      exp_w = model_pick(v);
      w = -1;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (bus.req_ready[i]) w = i;
      chk("grant_locked", 32'(bus.locked), 32'(m_locked));
      chk("grant_winner", w, exp_w);
      grant_log.push_back(w);
      if (w >= 0 && rq[w].size() > 0) begin
        front    = rq[w].pop_front();
        exp_en   = 1;
        exp_data = front[7:0];
        exp_gid  = w;
        if (uart_dead) begin
          err_pending = 1;
          m_locked    = 0;
          m_ptr       = (w + 1) % NUM_REQ;
        end else begin
          line_exp.push_back(front[7:0]);
          if (front[8]) begin
            m_locked = 0;
            m_ptr    = (w + 1) % NUM_REQ;
          end else begin
            m_locked = 1;
            m_owner  = w;
          end
        end
      end
    end
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (!queues_empty() && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", 32'(queues_empty()), 1);
    repeat (BUSY_LEN + START_TIMEOUT + 6) cycle();
  endtask

  task automatic run_until_grants(input int n, input int budget);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk("grant_wait", 32'(grant_log.size() >= n), 1);
  endtask

  task automatic do_reset();
    rst_req = 1;
    quiet   = 1;
    cycle();
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    m_ptr = 0; m_owner = 0; m_locked = 0;
    exp_en = 0; en_age = 1000; err_pending = 0; err_seen = 0;
    grant_log.delete(); line_act.delete(); line_exp.delete();
    rst_req = 0;
    cycle();
    chk("rst_tx_enable", 32'(bus.tx_enable), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_err", 32'(bus.err_timeout), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    quiet = 0;
  endtask

  task automatic check_lines(input string tag);
    chk({tag, "_model_n"}, line_act.size(), line_exp.size());
    for (int i = 0; i < line_act.size() && i < line_exp.size(); i++)
      chk({tag, "_model_byte"}, 32'(line_act[i]), 32'(line_exp[i]));
  endtask

  task automatic check_directed(input string tag);
    chk({tag, "_grant_n"}, grant_log.size(), exp_grants.size());
    for (int i = 0; i < grant_log.size() && i < exp_grants.size(); i++)
      chk({tag, "_grant"}, grant_log[i], exp_grants[i]);
    chk({tag, "_line_n"}, line_act.size(), exp_line.size());
    for (int i = 0; i < line_act.size() && i < exp_line.size(); i++)
      chk({tag, "_line"}, 32'(line_act[i]), 32'(exp_line[i]));
    check_lines(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] d;
    int nf, len;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    ext_busy = 0; ext_busy_req = 0;
    uart_dead = 0; rand_gate = 0; gate = '1;
    rst_req = 1; quiet = 1;

    // Single byte from requester 2, then pointer must sit at 3.
    do_reset();
    rq[2].push_back({1'b1, 8'h5A});
    drain(100);
    chk("t1_locked", 32'(bus.locked), 0);
    rq[0].push_back({1'b1, 8'h01});
    rq[3].push_back({1'b1, 8'h03});
    drain(200);
    exp_grants = '{2, 3, 0};
    exp_line   = '{8'h5A, 8'h03, 8'h01};
    check_directed("t1");

    // Round robin among 0,1,3.
    do_reset();
    rq[0].push_back({1'b1, 8'h10});
    rq[0].push_back({1'b1, 8'h10});
    rq[1].push_back({1'b1, 8'h11});
    rq[3].push_back({1'b1, 8'h13});
    drain(300);
    exp_grants = '{0, 1, 3, 0};
    exp_line   = '{8'h10, 8'h11, 8'h13, 8'h10};
    check_directed("t2");

    // Frame lock: requester 1 sends a 3-byte frame while 0 waits.
    do_reset();
    rq[1].push_back({1'b0, 8'hA0});
    rq[1].push_back({1'b0, 8'hA1});
    rq[1].push_back({1'b1, 8'hA2});
    run_until_grants(1, 50);
    rq[0].push_back({1'b1, 8'h55});
    run_until_grants(2, 100);
    chk("t3_locked_mid", 32'(bus.locked), 1);
    drain(300);
    exp_grants = '{1, 1, 1, 0};
    exp_line   = '{8'hA0, 8'hA1, 8'hA2, 8'h55};
    check_directed("t3");

    // Start timeout: uart never goes busy.
    do_reset();
    uart_dead = 1;
    rq[0].push_back({1'b0, 8'h40});
    rq[1].push_back({1'b1, 8'h41});
    drain(200);
    chk("t4_err_count", err_seen, 2);
    chk("t4_locked", 32'(bus.locked), 0);
    uart_dead = 0;
    exp_grants = '{0, 1};
    exp_line   = '{};
    check_directed("t4");

    // Busy gating.
    do_reset();
    ext_busy_req = 1;
    rq[0].push_back({1'b1, 8'h77});
    repeat (6) begin
      cycle();
      chk("t5_no_ready", 32'(bus.req_ready), 0);
      chk("t5_no_enable", 32'(bus.tx_enable), 0);
    end
    ext_busy_req = 0;
    cycle();
    chk("t5_first_idle_grant", 32'(bus.req_ready), 32'h1);
    drain(100);
    exp_grants = '{0};
    exp_line   = '{8'h77};
    check_directed("t5");

    // Reset in the middle of a locked frame.
    do_reset();
    rq[2].push_back({1'b0, 8'hB0});
    rq[2].push_back({1'b0, 8'hB1});
    run_until_grants(2, 100);
    k = 0;
    while (!bus.tx_busy && k < 50) begin
      cycle();
      k++;
    end
    chk("t6_in_flight", 32'(bus.tx_busy), 1);
    cycle();
    chk("t6_locked", 32'(bus.locked), 1);
    do_reset();
    rq[3].push_back({1'b1, 8'hD3});
    rq[0].push_back({1'b1, 8'hC0});
    drain(200);
    exp_grants = '{0, 3};
    exp_line   = '{8'hC0, 8'hD3};
    check_directed("t6");

    // Randomized frames with random valid gaps.
    do_reset();
    rand_gate = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            rq[i].push_back({(b == len - 1), d});
          end
        end
      end
      drain(3000);
    end
    rand_gate = 0;
    check_lines("rand");

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
`default_nettype wire
